// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, NOP encoding, reset PC and fetch FSM states.
package cpu_pkg;
   localparam logic [1:0]  EXC_NONE = 2'b00;
   localparam logic [1:0]  EXC_ADEL = 2'b01;
   localparam logic [1:0]  EXC_BUS  = 2'b10;
   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched entry, insert a bubble, or hold under ID stall.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RST_PC = cpu_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        hold_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [1:0]  exc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc8_o,
   output logic        valid_o,
   output logic [1:0]  exc_o
);
   logic [31:0] instr_q, pc_q, pc8_q;
   logic        valid_q;
   logic [1:0]  exc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP;
         pc_q    <= RST_PC;
         pc8_q   <= RST_PC + 32'd8;
         valid_q <= 1'b0;
         exc_q   <= EXC_NONE;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         pc8_q   <= pc_i + 32'd8;
         valid_q <= 1'b1;
         exc_q   <= exc_i;
      end else if (!hold_i) begin
         // Bubble keeps the last PC so pc_d/pc8_d stay meaningful for debug.
         instr_q <= NOP;
         valid_q <= 1'b0;
         exc_q   <= EXC_NONE;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign pc8_o   = pc8_q;
   assign valid_o = valid_q;
   assign exc_o   = exc_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: address check, req/ack handshake with timeout, and IF/ID load control.
module if_fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int unsigned IM_BYTES = 4096,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        stall_d,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        fetch_stall,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic [1:0]  exc_d
);
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
   localparam logic [32:0] LO_X    = {1'b0, IM_BASE};
   localparam logic [32:0] HI_X    = {1'b0, IM_BASE} + 33'(IM_BYTES);

   fetch_state_e state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [1:0]   buf_exc_q, buf_exc_d;
   logic         abort_q, abort_d;
   logic         accept, bad;
   logic [31:0]  acc_instr;
   logic [1:0]   acc_exc;

   // 33-bit compare so the top of the address space cannot wrap into range.
   assign bad = (pc[1:0] != 2'b00) | ({1'b0, pc} < LO_X) | ({1'b0, pc} >= HI_X);
   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         cnt_q       <= '0;
         buf_instr_q <= NOP;
         buf_exc_q   <= EXC_NONE;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_instr_q <= buf_instr_d;
         buf_exc_q   <= buf_exc_d;
         abort_q     <= abort_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_instr_d = buf_instr_q;
      buf_exc_d   = buf_exc_q;
      abort_d     = 1'b0;
      accept      = 1'b0;
      acc_instr   = NOP;
      acc_exc     = EXC_NONE;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               if (abort_q) begin
                  // One idle cycle with req low so memory drops the timed-out access.
                  cnt_d = '0;
               end else if (bad) begin
                  cnt_d = '0;
                  if (!stall_d) begin
                     accept  = 1'b1;
                     acc_exc = EXC_ADEL;
                  end else begin
                     buf_instr_d = NOP;
                     buf_exc_d   = EXC_ADEL;
                     state_d     = HOLD;
                  end
               end else if (imem_ack) begin
                  cnt_d = '0;
                  if (!stall_d) begin
                     accept    = 1'b1;
                     acc_instr = imem_rdata;
                  end else begin
                     buf_instr_d = imem_rdata;
                     buf_exc_d   = EXC_NONE;
                     state_d     = HOLD;
                  end
               end else if (cnt_q == TO_LAST) begin
                  cnt_d   = '0;
                  abort_d = 1'b1;
                  if (!stall_d) begin
                     accept  = 1'b1;
                     acc_exc = EXC_BUS;
                  end else begin
                     buf_instr_d = NOP;
                     buf_exc_d   = EXC_BUS;
                     state_d     = HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            HOLD: begin
               if (!stall_d) begin
                  accept    = 1'b1;
                  acc_instr = buf_instr_q;
                  acc_exc   = buf_exc_q;
                  state_d   = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_comb begin
      imem_req    = (state_q == FETCH) & !bad & !abort_q & !rst;
      fetch_stall = !accept;
   end

   if_id_reg #(.RST_PC(RESET_PC)) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .hold_i  (stall_d),
      .instr_i (acc_instr),
      .pc_i    (pc),
      .exc_i   (acc_exc),
      .instr_o (instr_d),
      .pc_o    (pc_d),
      .pc8_o   (pc8_d),
      .valid_o (valid_d),
      .exc_o   (exc_d)
   );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: handshake, stalls, address faults, timeout, reset.
module tb_if_fetch_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        stall_d;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        fetch_stall;
   logic [31:0] instr_d, pc_d, pc8_d;
   logic        valid_d;
   logic [1:0]  exc_d;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .pc(pc), .stall_d(stall_d),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .fetch_stall(fetch_stall),
      .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
      .valid_d(valid_d), .exc_d(exc_d)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc = 32'h3000; stall_d = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
      repeat (3) step();
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      n_chk++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got=%b exp=1", fetch_stall); end
      n_chk++; if (instr_d !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", instr_d); end
      n_chk++; if (pc_d !== 32'h3000) begin n_fail++; $display("FAIL rst_pc got=%h exp=3000", pc_d); end
      n_chk++; if (pc8_d !== 32'h3008) begin n_fail++; $display("FAIL rst_pc8 got=%h exp=3008", pc8_d); end
      n_chk++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", valid_d); end
      n_chk++; if (exc_d !== 2'b00) begin n_fail++; $display("FAIL rst_exc got=%b exp=00", exc_d); end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req got=%b exp=1", imem_req); end
      n_chk++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL zw_addr got=%h exp=3000", imem_addr); end
      n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL zw_stall got=%b exp=0", fetch_stall); end
      step();
      n_chk++; if (instr_d !== 32'h3C01_1234) begin n_fail++; $display("FAIL zw_instr got=%h exp=3c011234", instr_d); end
      n_chk++; if (pc_d !== 32'h3000) begin n_fail++; $display("FAIL zw_pc got=%h exp=3000", pc_d); end
      n_chk++; if (pc8_d !== 32'h3008) begin n_fail++; $display("FAIL zw_pc8 got=%h exp=3008", pc8_d); end
      n_chk++; if (valid_d !== 1'b1 || exc_d !== 2'b00) begin n_fail++; $display("FAIL zw_vld got=%b/%b exp=1/00", valid_d, exc_d); end
   endtask

   task automatic test_back_to_back();
      pc = 32'h3004; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      #1;
      n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", fetch_stall); end
      step();
      n_chk++; if (instr_d !== 32'h8C22_0004 || pc_d !== 32'h3004) begin n_fail++; $display("FAIL b2b_instr got=%h@%h exp=8c220004@3004", instr_d, pc_d); end
      n_chk++; if (pc8_d !== 32'h300C) begin n_fail++; $display("FAIL b2b_pc8 got=%h exp=300c", pc8_d); end
      imem_ack = 1'b0;
   endtask

   task automatic test_wait_states();
      pc = 32'h3008; imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (fetch_stall !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_wait%0d got stall=%b req=%b exp=1/1", i, fetch_stall, imem_req); end
         step();
         n_chk++; if (valid_d !== 1'b0 || pc_d !== 32'h3004) begin n_fail++; $display("FAIL ws_bubble%0d got vld=%b pc=%h exp=0/3004", i, valid_d, pc_d); end
      end
      imem_ack = 1'b1; imem_rdata = 32'h2402_0005;
      #1;
      n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL ws_acc_stall got=%b exp=0", fetch_stall); end
      step();
      n_chk++; if (instr_d !== 32'h2402_0005 || pc_d !== 32'h3008 || valid_d !== 1'b1) begin n_fail++; $display("FAIL ws_load got=%h@%h v=%b exp=24020005@3008 v=1", instr_d, pc_d, valid_d); end
      imem_ack = 1'b0;
   endtask

   task automatic test_stall_ack();
      pc = 32'h300C; stall_d = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
      #1;
      n_chk++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL sa_stall got=%b exp=1", fetch_stall); end
      step();
      imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_chk++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin n_fail++; $display("FAIL sa_hold%0d got req=%b stall=%b exp=0/1", i, imem_req, fetch_stall); end
         n_chk++; if (instr_d !== 32'h2402_0005 || pc_d !== 32'h3008 || valid_d !== 1'b1) begin n_fail++; $display("FAIL sa_ifid%0d got=%h@%h v=%b exp=24020005@3008 v=1", i, instr_d, pc_d, valid_d); end
         if (i == 0) step();
      end
      stall_d = 1'b0;
      #1;
      n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL sa_rel_stall got=%b exp=0", fetch_stall); end
      step();
      n_chk++; if (instr_d !== 32'h20 || pc_d !== 32'h300C || valid_d !== 1'b1 || exc_d !== 2'b00) begin n_fail++; $display("FAIL sa_load got=%h@%h v=%b e=%b exp=20@300c v=1 e=00", instr_d, pc_d, valid_d, exc_d); end
   endtask

   task automatic test_bad_addr();
      pc = 32'h3002; imem_ack = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0) begin n_fail++; $display("FAIL mis_req got req=%b stall=%b exp=0/0", imem_req, fetch_stall); end
      step();
      n_chk++; if (exc_d !== 2'b01 || instr_d !== 32'h0 || valid_d !== 1'b1 || pc8_d !== 32'h300A) begin n_fail++; $display("FAIL mis_ifid got e=%b i=%h v=%b pc8=%h exp=01/0/1/300a", exc_d, instr_d, valid_d, pc8_d); end
      pc = 32'h4000;
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hi_req got=%b exp=0", imem_req); end
      step();
      n_chk++; if (exc_d !== 2'b01 || pc_d !== 32'h4000) begin n_fail++; $display("FAIL hi_exc got=%b@%h exp=01@4000", exc_d, pc_d); end
      pc = 32'hFFFF_FFFC;
      step();
      n_chk++; if (exc_d !== 2'b01 || pc8_d !== 32'h0000_0004) begin n_fail++; $display("FAIL top_exc got=%b pc8=%h exp=01/4", exc_d, pc8_d); end
      pc = 32'h2FFC;
      step();
      n_chk++; if (exc_d !== 2'b01) begin n_fail++; $display("FAIL lo_exc got=%b exp=01", exc_d); end
      pc = 32'h4004; stall_d = 1'b1;
      step();
      n_chk++; if (imem_req !== 1'b0 || pc_d !== 32'h2FFC) begin n_fail++; $display("FAIL badhold got req=%b pc=%h exp=0/2ffc", imem_req, pc_d); end
      stall_d = 1'b0;
      step();
      n_chk++; if (exc_d !== 2'b01 || pc_d !== 32'h4004 || valid_d !== 1'b1) begin n_fail++; $display("FAIL badrel got e=%b pc=%h v=%b exp=01/4004/1", exc_d, pc_d, valid_d); end
      pc = 32'h3FFC;
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL edge_req got=%b exp=1", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
      step();
      n_chk++; if (exc_d !== 2'b00 || instr_d !== 32'hAAAA_0001 || pc_d !== 32'h3FFC) begin n_fail++; $display("FAIL edge_load got e=%b i=%h pc=%h exp=00/aaaa0001/3ffc", exc_d, instr_d, pc_d); end
      imem_ack = 1'b0;
   endtask

   task automatic test_timeout();
      pc = 32'h3010; imem_ack = 1'b0;
      for (int i = 0; i < 14; i++) begin
         #1;
         n_chk++; if (fetch_stall !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d got stall=%b req=%b exp=1/1", i, fetch_stall, imem_req); end
         step();
      end
      #1;
      n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL to_acc got=%b exp=0", fetch_stall); end
      step();
      n_chk++; if (exc_d !== 2'b10 || instr_d !== 32'h0 || valid_d !== 1'b1 || pc_d !== 32'h3010) begin n_fail++; $display("FAIL to_ifid got e=%b i=%h v=%b pc=%h exp=10/0/1/3010", exc_d, instr_d, valid_d, pc_d); end
      pc = 32'h3014;
      #1;
      n_chk++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin n_fail++; $display("FAIL to_drop got req=%b stall=%b exp=0/1", imem_req, fetch_stall); end
      step();
      n_chk++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL to_bubble got=%b exp=0", valid_d); end
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL to_rereq got=%b exp=1", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0005;
      step();
      n_chk++; if (instr_d !== 32'h5 || pc_d !== 32'h3014 || exc_d !== 2'b00) begin n_fail++; $display("FAIL to_next got i=%h pc=%h e=%b exp=5/3014/00", instr_d, pc_d, exc_d); end
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      pc = 32'h3020; imem_ack = 1'b0;
      step();
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_pend got=%b exp=1", imem_req); end
      rst = 1'b1; pc = 32'h3000;
      #1;
      n_chk++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rm_req got req=%b stall=%b exp=0/1", imem_req, fetch_stall); end
      n_chk++; if (valid_d !== 1'b0 || pc_d !== 32'h3000 || instr_d !== 32'h0) begin n_fail++; $display("FAIL rm_ifid got v=%b pc=%h i=%h exp=0/3000/0", valid_d, pc_d, instr_d); end
      step(); step();
      rst = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rm_first got req=%b addr=%h stall=%b exp=1/3000/1", imem_req, imem_addr, fetch_stall); end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      step();
      n_chk++; if (instr_d !== 32'h1111_2222 || pc_d !== 32'h3000 || valid_d !== 1'b1) begin n_fail++; $display("FAIL rm_load got i=%h pc=%h v=%b exp=11112222/3000/1", instr_d, pc_d, valid_d); end
      imem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_back_to_back();
      test_wait_states();
      test_stall_ack();
      test_bad_addr();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
